// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter (icache = m0, dcache = m1) with round-robin
// contention, burst-safe handover and an optional strobe timeout that drains the offender.
module zap_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_wen,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_dat,
  input  logic [31:0] i_m0_adr,
  input  logic [2:0]  i_m0_cti,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_dat,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_wen,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_dat,
  input  logic [31:0] i_m1_adr,
  input  logic [2:0]  i_m1_cti,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic [31:0] o_wb_adr,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  output logic [1:0]  o_grant
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT0,
    S_GNT1,
    S_DRAIN0,
    S_DRAIN1
  } state_t;

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;

  logic own0, own1;
  logic own_cyc, pending, timeout, handover;

  assign own0 = (state_q == S_GNT0);
  assign own1 = (state_q == S_GNT1);

  assign o_grant  = {own1, own0};
  assign o_m0_ack = own0 & i_wb_ack;
  assign o_m1_ack = own1 & i_wb_ack;
  assign o_m0_err = err0_q;
  assign o_m1_err = err1_q;
  assign o_m0_dat = i_wb_dat;
  assign o_m1_dat = i_wb_dat;

  // Owner's request passes straight through; otherwise the bus is parked.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_wen = 1'b0;
    o_wb_sel = 4'd0;
    o_wb_dat = 32'd0;
    o_wb_adr = 32'd0;
    o_wb_cti = 3'b111;
    if (own0) begin
      o_wb_cyc = i_m0_cyc;
      o_wb_stb = i_m0_stb;
      o_wb_wen = i_m0_wen;
      o_wb_sel = i_m0_sel;
      o_wb_dat = i_m0_dat;
      o_wb_adr = i_m0_adr;
      o_wb_cti = i_m0_cti;
    end else if (own1) begin
      o_wb_cyc = i_m1_cyc;
      o_wb_stb = i_m1_stb;
      o_wb_wen = i_m1_wen;
      o_wb_sel = i_m1_sel;
      o_wb_dat = i_m1_dat;
      o_wb_adr = i_m1_adr;
      o_wb_cti = i_m1_cti;
    end
  end

  assign own_cyc  = own1 ? i_m1_cyc : i_m0_cyc;
  assign pending  = (own0 | own1) & o_wb_stb & ~i_wb_ack;
  assign timeout  = TO_EN & pending & (cnt_q == TIMEOUT_C);
  // Ownership may only move once the current strobe has been retired.
  assign handover = ~own_cyc & (~o_wb_stb | i_wb_ack);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    cnt_d      = pending ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1)) : '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_gnt_q)) begin
          state_d    = S_GNT0;
          last_gnt_d = 1'b0;
        end else if (i_m1_cyc) begin
          state_d    = S_GNT1;
          last_gnt_d = 1'b1;
        end
      end
      S_GNT0: begin
        if (timeout) begin
          state_d = S_DRAIN0;
          err0_d  = 1'b1;
        end else if (handover) begin
          if (i_m1_cyc) begin
            state_d    = S_GNT1;
            last_gnt_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GNT1: begin
        if (timeout) begin
          state_d = S_DRAIN1;
          err1_d  = 1'b1;
        end else if (handover) begin
          if (i_m0_cyc) begin
            state_d    = S_GNT0;
            last_gnt_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN0: if (!i_m0_cyc) state_d = S_IDLE;
      S_DRAIN1: if (!i_m1_cyc) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Scoreboard bench: two arbiters (TIMEOUT=4 and TIMEOUT=0) share one stimulus stream
// and are checked every cycle against an owner/drain reference model.
module tb_zap_wb_arbiter;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [2:0]  cti;
  } mreq_t;

  typedef struct {
    logic        rst;
    mreq_t       m [2];
    logic        ack;
    logic [31:0] wdat;
  } stim_t;

  typedef struct {
    logic [1:0]  grant;
    mreq_t       bus;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] mdat0;
    logic [31:0] mdat1;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } sb_t;

  typedef struct {
    bit       known;
    int       owner;
    bit       drain;
    bit       last;
    int       waitc;
    bit [1:0] err;
  } mst_t;

  localparam mreq_t PARKED = '{cyc: 1'b0, stb: 1'b0, wen: 1'b0, sel: 4'd0,
                               dat: 32'd0, adr: 32'd0, cti: 3'b111};

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_cyc, i_m0_stb, i_m0_wen, i_m1_cyc, i_m1_stb, i_m1_wen;
  logic [3:0]  i_m0_sel, i_m1_sel;
  logic [31:0] i_m0_dat, i_m0_adr, i_m1_dat, i_m1_adr;
  logic [2:0]  i_m0_cti, i_m1_cti;
  logic        i_wb_ack;
  logic [31:0] i_wb_dat;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic [31:0] a_m0_dat, a_m1_dat;
  logic        a_wb_cyc, a_wb_stb, a_wb_wen;
  logic [3:0]  a_wb_sel;
  logic [31:0] a_wb_dat, a_wb_adr;
  logic [2:0]  a_wb_cti;
  logic [1:0]  a_grant;

  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [31:0] b_m0_dat, b_m1_dat;
  logic        b_wb_cyc, b_wb_stb, b_wb_wen;
  logic [3:0]  b_wb_sel;
  logic [31:0] b_wb_dat, b_wb_adr;
  logic [2:0]  b_wb_cti;
  logic [1:0]  b_grant;

  always #5 i_clk = ~i_clk;

  zap_wb_arbiter #(.TIMEOUT(4)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_wen(i_m0_wen), .i_m0_sel(i_m0_sel),
    .i_m0_dat(i_m0_dat), .i_m0_adr(i_m0_adr), .i_m0_cti(i_m0_cti),
    .o_m0_ack(a_m0_ack), .o_m0_err(a_m0_err), .o_m0_dat(a_m0_dat),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_wen(i_m1_wen), .i_m1_sel(i_m1_sel),
    .i_m1_dat(i_m1_dat), .i_m1_adr(i_m1_adr), .i_m1_cti(i_m1_cti),
    .o_m1_ack(a_m1_ack), .o_m1_err(a_m1_err), .o_m1_dat(a_m1_dat),
    .o_wb_cyc(a_wb_cyc), .o_wb_stb(a_wb_stb), .o_wb_wen(a_wb_wen), .o_wb_sel(a_wb_sel),
    .o_wb_dat(a_wb_dat), .o_wb_adr(a_wb_adr), .o_wb_cti(a_wb_cti),
    .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat), .o_grant(a_grant)
  );

  zap_wb_arbiter #(.TIMEOUT(0)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_wen(i_m0_wen), .i_m0_sel(i_m0_sel),
    .i_m0_dat(i_m0_dat), .i_m0_adr(i_m0_adr), .i_m0_cti(i_m0_cti),
    .o_m0_ack(b_m0_ack), .o_m0_err(b_m0_err), .o_m0_dat(b_m0_dat),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_wen(i_m1_wen), .i_m1_sel(i_m1_sel),
    .i_m1_dat(i_m1_dat), .i_m1_adr(i_m1_adr), .i_m1_cti(i_m1_cti),
    .o_m1_ack(b_m1_ack), .o_m1_err(b_m1_err), .o_m1_dat(b_m1_dat),
    .o_wb_cyc(b_wb_cyc), .o_wb_stb(b_wb_stb), .o_wb_wen(b_wb_wen), .o_wb_sel(b_wb_sel),
    .o_wb_dat(b_wb_dat), .o_wb_adr(b_wb_adr), .o_wb_cti(b_wb_cti),
    .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat), .o_grant(b_grant)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    a_err0_seen = 0;
  int    b_err_seen = 0;
  sb_t   sbq[$];
  sb_t   mon_e;
  exp_t  act_a, act_b;
  stim_t s;
  mst_t  ma, mb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Expected outputs for the current cycle, from who owns the bus.
  function automatic exp_t model_out(mst_t m, stim_t x);
    exp_t e;
    bit   g = (m.owner >= 0) && !m.drain;
    e.grant = 2'b00;
    e.bus   = PARKED;
    e.ack   = 2'b00;
    if (g) begin
      e.grant[m.owner] = 1'b1;
      e.bus            = x.m[m.owner];
      e.ack[m.owner]   = x.ack;
    end
    e.err   = m.err;
    e.mdat0 = x.wdat;
    e.mdat1 = x.wdat;
    return e;
  endfunction

  function automatic mst_t model_next(int t, mst_t m, stim_t x);
    mst_t n = m;
    int   o = m.owner;
    n.err = 2'b00;
    if (x.rst) begin
      n.known = 1'b1; n.owner = -1; n.drain = 1'b0; n.last = 1'b1; n.waitc = 0;
    end else if (o >= 0 && !m.drain) begin
      bit pend = x.m[o].stb && !x.ack;
      n.waitc = pend ? ((m.waitc < 65535) ? m.waitc + 1 : 65535) : 0;
      if (t != 0 && pend && m.waitc == t) begin
        n.err[o] = 1'b1;
        n.drain  = 1'b1;
      end else if (!x.m[o].cyc && (!x.m[o].stb || x.ack)) begin
        if (x.m[1-o].cyc) begin
          n.owner = 1 - o;
          n.last  = (n.owner == 1);
        end else begin
          n.owner = -1;
        end
      end
    end else if (m.drain) begin
      n.waitc = 0;
      if (!x.m[o].cyc) begin
        n.drain = 1'b0;
        n.owner = -1;
      end
    end else begin
      n.waitc = 0;
      if (x.m[0].cyc && x.m[1].cyc) n.owner = m.last ? 0 : 1;
      else if (x.m[0].cyc)          n.owner = 0;
      else if (x.m[1].cyc)          n.owner = 1;
      if (n.owner >= 0) n.last = (n.owner == 1);
    end
    return n;
  endfunction

  function automatic mreq_t rnd_req(logic c, logic st, logic [2:0] cti);
    mreq_t r;
    r.cyc = c;
    r.stb = st;
    r.wen = 1'($urandom);
    r.sel = 4'($urandom);
    r.dat = $urandom;
    r.adr = $urandom;
    r.cti = cti;
    return r;
  endfunction

  task automatic step();
    sb_t e;
    @(posedge i_clk);
    #1;
    i_reset  = s.rst;
    {i_m0_cyc, i_m0_stb, i_m0_wen, i_m0_sel, i_m0_dat, i_m0_adr, i_m0_cti} = s.m[0];
    {i_m1_cyc, i_m1_stb, i_m1_wen, i_m1_sel, i_m1_dat, i_m1_adr, i_m1_cti} = s.m[1];
    i_wb_ack = s.ack;
    i_wb_dat = s.wdat;
    if (ma.known) begin
      e.a = model_out(ma, s);
      e.b = model_out(mb, s);
      sbq.push_back(e);
    end
    ma = model_next(4, ma, s);
    mb = model_next(0, mb, s);
  endtask

  task automatic quiet(int n);
    s.m[0] = rnd_req(1'b0, 1'b0, 3'($urandom));
    s.m[1] = rnd_req(1'b0, 1'b0, 3'($urandom));
    s.ack  = 1'b0;
    for (int i = 0; i < n; i++) begin
      s.wdat = $urandom;
      step();
    end
  endtask

  // Monitor: every presented cycle is compared against the oldest expectation.
  always @(negedge i_clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      act_a.grant = a_grant;
      act_a.bus   = {a_wb_cyc, a_wb_stb, a_wb_wen, a_wb_sel, a_wb_dat, a_wb_adr, a_wb_cti};
      act_a.ack   = {a_m1_ack, a_m0_ack};
      act_a.err   = {a_m1_err, a_m0_err};
      act_b.grant = b_grant;
      act_b.bus   = {b_wb_cyc, b_wb_stb, b_wb_wen, b_wb_sel, b_wb_dat, b_wb_adr, b_wb_cti};
      act_b.ack   = {b_m1_ack, b_m0_ack};
      act_b.err   = {b_m1_err, b_m0_err};
      chk("a_grant",  128'(act_a.grant), 128'(mon_e.a.grant));
      chk("a_bus",    128'(act_a.bus),   128'(mon_e.a.bus));
      chk("a_ack",    128'(act_a.ack),   128'(mon_e.a.ack));
      chk("a_err",    128'(act_a.err),   128'(mon_e.a.err));
      chk("a_m0_dat", 128'(a_m0_dat),    128'(mon_e.a.mdat0));
      chk("a_m1_dat", 128'(a_m1_dat),    128'(mon_e.a.mdat1));
      chk("b_grant",  128'(act_b.grant), 128'(mon_e.b.grant));
      chk("b_bus",    128'(act_b.bus),   128'(mon_e.b.bus));
      chk("b_ack",    128'(act_b.ack),   128'(mon_e.b.ack));
      chk("b_err",    128'(act_b.err),   128'(mon_e.b.err));
      if (a_m0_err === 1'b1) a_err0_seen++;
      if (b_m0_err === 1'b1 || b_m1_err === 1'b1) b_err_seen++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '{known: 1'b0, owner: -1, drain: 1'b0, last: 1'b1, waitc: 0, err: 2'b00};
    mb = ma;
    s.rst = 1'b1;
    quiet(3);
    s.rst = 1'b0;
    quiet(1);

    // Simultaneous request after reset: m0 first, then direct handover to m1.
    s.m[0] = rnd_req(1'b1, 1'b1, 3'b111);
    s.m[1] = rnd_req(1'b1, 1'b1, 3'b111);
    step();
    s.ack = 1'b1; step();
    s.m[0] = rnd_req(1'b0, 1'b0, 3'b111); s.ack = 1'b0; step();
    s.ack = 1'b1; step();
    s.m[1] = rnd_req(1'b0, 1'b0, 3'b111); s.ack = 1'b0; step();
    quiet(2);

    // m1 burst is not split by m0 arriving mid-burst.
    s.m[1] = rnd_req(1'b1, 1'b1, 3'b010);
    step();
    for (int b = 0; b < 4; b++) begin
      s.m[1] = rnd_req(1'b1, 1'b1, (b == 3) ? 3'b111 : 3'b010);
      if (b == 1) s.m[0] = rnd_req(1'b1, 1'b1, 3'b111);
      s.ack = 1'b1;
      s.wdat = $urandom;
      step();
    end
    s.m[1] = rnd_req(1'b0, 1'b0, 3'b111); s.ack = 1'b0; step();
    s.ack = 1'b1; step();
    quiet(2);

    // Unacknowledged strobe on m0: exactly one error pulse, drain until cyc drops.
    a_err0_seen = 0;
    s.m[0] = rnd_req(1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 12; i++) step();
    quiet(3);
    chk("timeout_err_once", 128'(a_err0_seen), 128'(1));

    // Ack arriving in the very cycle the count hits TIMEOUT wins.
    a_err0_seen = 0;
    s.m[0] = rnd_req(1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 5; i++) step();
    s.ack = 1'b1; step();
    s.m[0] = rnd_req(1'b0, 1'b0, 3'b111); s.ack = 1'b0; step();
    quiet(3);
    chk("ack_beats_timeout", 128'(a_err0_seen), 128'(0));

    // Reset in the middle of an m1 transfer.
    s.m[1] = rnd_req(1'b1, 1'b1, 3'b010);
    step(); step();
    s.rst = 1'b1; s.ack = 1'b1; step();
    s.rst = 1'b0; step();
    quiet(2);

    // Randomized traffic with varying slave responsiveness.
    for (int blk = 0; blk < 8; blk++) begin
      int pct = (blk % 4 == 0) ? 70 : (blk % 4 == 1) ? 15 : (blk % 4 == 2) ? 3 : 95;
      for (int i = 0; i < 500; i++) begin
        for (int k = 0; k < 2; k++) begin
          logic c = s.m[k].cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
          s.m[k] = rnd_req(c, c & 1'($urandom), 3'($urandom));
        end
        s.ack  = ($urandom_range(0, 99) < pct);
        s.wdat = $urandom;
        s.rst  = ($urandom_range(0, 999) == 0);
        step();
      end
    end
    s.rst = 1'b1; quiet(1);
    s.rst = 1'b0; quiet(2);

    // Long stall: TIMEOUT=0 instance never errors even past counter saturation.
    b_err_seen = 0;
    s.m[0] = rnd_req(1'b1, 1'b1, 3'b111);
    s.m[1] = rnd_req(1'b0, 1'b0, 3'b111);
    s.ack  = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    s.ack = 1'b1; step();
    quiet(3);
    chk("no_err_when_disabled", 128'(b_err_seen), 128'(0));

    @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zap_wb_arbiter.md
ZAP_WB_ARBITER -- requirements
Module: zap_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: cycles of unacknowledged strobe before an error; 0 disables the timeout; legal range 0..65535.
REQ-002 i_clk  input  1  clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_m0_cyc, i_m0_stb, i_m0_wen  input  1 each  master 0 (icache) Wishbone cycle, strobe and write enable.
REQ-005 i_m0_sel  input  4; i_m0_dat  input  32; i_m0_adr  input  32; i_m0_cti  input  3  master 0 byte select, write data, address and cycle type.
REQ-006 o_m0_ack  output  1; o_m0_err  output  1; o_m0_dat  output  32  master 0 acknowledge, error and read data.
REQ-007 i_m1_* and o_m1_*  same directions and widths as REQ-004..006  master 1 (dcache).
REQ-008 o_wb_cyc, o_wb_stb, o_wb_wen  output  1 each; o_wb_sel  output  4; o_wb_dat  output  32; o_wb_adr  output  32; o_wb_cti  output  3  shared slave bus.
REQ-009 i_wb_ack  input  1; i_wb_dat  input  32  slave acknowledge and read data.
REQ-010 o_grant  output  2  one-hot owner of the bus: bit 0 for master 0, bit 1 for master 1, 00 when no master owns it.

Function
REQ-011 The block SHALL implement registered states IDLE, GNT0, GNT1, DRAIN0 and DRAIN1.
REQ-012 In IDLE, o_wb_* SHALL all be zero and o_wb_cti SHALL equal 3'b111.
REQ-013 In GNTn, o_wb_* SHALL be combinationally equal to master n's inputs.
REQ-014 In DRAINn, bus outputs SHALL behave as in IDLE.
REQ-015 o_grant SHALL be 01 in GNT0, 10 in GNT1 and 00 in all other states.
REQ-016 o_mN_ack SHALL equal i_wb_ack while in GNTn and 0 otherwise.
REQ-017 o_mN_dat SHALL equal i_wb_dat at all times.
REQ-018 From IDLE with only master n's cyc high, the next state SHALL be GNTn, giving one cycle of grant latency.
REQ-019 From IDLE with both masters' cyc high, the grant SHALL go to the master that is not last_gnt (round-robin).
REQ-020 last_gnt is a 1-bit register updated on every entry to GNTn.
REQ-021 In GNTn, a change of owner SHALL occur only when o_wb_stb is 0 or (o_wb_stb and i_wb_ack) in the current cycle; a multi-beat burst is therefore never split.
REQ-022 In GNTn, when master n's cyc is 0: if the other master's cyc is 1, the next state SHALL be the other master's GNT state directly; otherwise the next state SHALL be IDLE.
REQ-023 A 16-bit counter SHALL clear whenever the state is not GNTn, o_wb_stb is 0, or i_wb_ack is 1.
REQ-024 Otherwise the counter SHALL increment by 1 per cycle and saturate at 65535.
REQ-025 When TIMEOUT is nonzero, the counter equals TIMEOUT and i_wb_ack is 0, o_mN_err SHALL pulse for exactly one cycle and the next state SHALL be DRAINn.
REQ-026 If i_wb_ack is 1 in the cycle the counter reaches TIMEOUT, the ack SHALL win: no error, and the counter clears.
REQ-027 In DRAINn, the block SHALL wait until master n's cyc is 0 and then go to IDLE, never directly to a GNT state.
REQ-028 In DRAINn, last_gnt SHALL equal n, so the other master wins the next contention.
REQ-029 o_mN_err SHALL be 0 in every cycle except the timeout pulse.
REQ-030 Each master's inputs SHALL be ignored whenever that master does not own the grant.

Reset
REQ-031 While i_reset is high, the state SHALL go to IDLE, last_gnt to 1, the counter to 0 and o_mN_err to 0, so master 0 wins the first contention.
REQ-032 Reset asserted mid-burst SHALL abort the transaction.
REQ-033 In the cycle after reset, o_grant SHALL be 00 and o_wb_cyc and o_wb_stb SHALL be 0.

Verification
REQ-034 Reset, then both cyc high in the same cycle -> next cycle o_grant=01 and o_wb_adr=i_m0_adr; after m0 drops cyc, o_grant=10 with no IDLE cycle in between.
REQ-035 m1 runs a 4-beat burst (cti 010,010,010,111) while m0 raises cyc at beat 2 -> o_grant stays 10 through the 4th ack and switches to 01 the cycle after m1 drops cyc.
REQ-036 TIMEOUT=4, m0 stb held with no ack -> o_m0_err high exactly once, 4 cycles after the count starts; state DRAIN0 with o_wb_cyc=0 until m0 drops cyc, then IDLE.
REQ-037 TIMEOUT=4, i_wb_ack arrives in the same cycle the counter reaches 4 -> o_m0_ack=1, o_m0_err=0, grant kept.
REQ-038 Reset asserted during GNT1 with stb high -> next cycle o_grant=00, o_wb_stb=0, and o_m1_ack=0 even if i_wb_ack=1.
REQ-039 TIMEOUT=0, stb held unacknowledged for 70000 cycles -> no err; the counter saturates at 65535 without wrapping.
